// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IFETCH  = 2'd1,
      DACCESS = 2'd2,
      RESP    = 2'd3
   } arbState_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one memory bus, one transaction at a time.
// Define MEM_ARB_RR_EN to alternate grants under contention instead of favouring data.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            IReqF,
   input  logic [XLEN-1:0] IAddrF,
   output logic [XLEN-1:0] IRdataF,
   output logic            IReadyF,
   input  logic            DReqM,
   input  logic            DWeM,
   input  logic [XLEN-1:0] DAddrM,
   input  logic [XLEN-1:0] DWdataM,
   output logic [XLEN-1:0] DRdataM,
   output logic            DReadyM,
   output logic            MemReq,
   output logic            MemWe,
   output logic [XLEN-1:0] MemAddr,
   output logic [XLEN-1:0] MemWdata,
   input  logic [XLEN-1:0] MemRdata,
   input  logic            MemAck,
   output logic            StallF,
   output logic            StallM
);

   arbState_t state;
   logic      grantData;

`ifdef MEM_ARB_RR_EN
   logic lastGrantData;

   // Under contention, hand the bus to whoever did not get it last time.
   always_comb begin
      grantData = DReqM;
      if (DReqM && IReqF) begin
         grantData = ~lastGrantData;
      end
   end

   // Reset leaves fetch as the last winner so data wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrantData <= 1'b0;
      end else if (state == IDLE && (DReqM || IReqF)) begin
         lastGrantData <= grantData;
      end
   end
`else
   always_comb begin
      grantData = DReqM;
   end
`endif

   // Main controller; every bus and response output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         MemReq   <= 1'b0;
         MemWe    <= 1'b0;
         MemAddr  <= '0;
         MemWdata <= '0;
         IRdataF  <= '0;
         DRdataM  <= '0;
         IReadyF  <= 1'b0;
         DReadyM  <= 1'b0;
      end else begin
         IReadyF <= 1'b0;
         DReadyM <= 1'b0;
         case (state)
            IDLE: begin
               if (grantData) begin
                  MemReq   <= 1'b1;
                  MemWe    <= DWeM;
                  MemAddr  <= DAddrM;
                  MemWdata <= DWdataM;
                  state    <= DACCESS;
               end else if (IReqF) begin
                  MemReq  <= 1'b1;
                  MemWe   <= 1'b0;
                  MemAddr <= IAddrF;
                  state   <= IFETCH;
               end
            end
            IFETCH: begin
               if (MemAck) begin
                  IRdataF <= MemRdata;
                  IReadyF <= 1'b1;
                  MemReq  <= 1'b0;
                  state   <= RESP;
               end
            end
            DACCESS: begin
               if (MemAck) begin
                  if (!MemWe) begin
                     DRdataM <= MemRdata;
                  end
                  DReadyM <= 1'b1;
                  MemReq  <= 1'b0;
                  MemWe   <= 1'b0;
                  state   <= RESP;
               end
            end
            // The ready pulse is visible here; never grant in this cycle.
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign StallF = IReqF & ~IReadyF;
   assign StallM = DReqM & ~DReadyM;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        IReqF;
   logic [31:0] IAddrF;
   logic [31:0] IRdataF;
   logic        IReadyF;
   logic        DReqM;
   logic        DWeM;
   logic [31:0] DAddrM;
   logic [31:0] DWdataM;
   logic [31:0] DRdataM;
   logic        DReadyM;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWdata;
   logic [31:0] MemRdata;
   logic        MemAck;
   logic        StallF;
   logic        StallM;

   int checks = 0;
   int errors = 0;

   // Reference model state: arbitration history and the last delivered read data.
   bit          rrEn;
   bit          lastWasData;
   logic [31:0] expIR;
   logic [31:0] expDR;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF), .IReadyF(IReadyF),
      .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
      .DRdataM(DRdataM), .DReadyM(DReadyM),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
      .MemRdata(MemRdata), .MemAck(MemAck),
      .StallF(StallF), .StallM(StallM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit pickData(input bit wantI, input bit wantD);
      if (wantI && wantD) return rrEn ? !lastWasData : 1'b1;
      return wantD;
   endfunction

   // Memory-side responder: waits for MemReq, holds it for lat cycles, then acks once.
   task automatic serveMem(input int lat, input logic [31:0] rdata,
                           output logic [31:0] addr, output logic we,
                           output logic [31:0] wdata, output int waitTicks, output bit ok);
      ok = 0;
      waitTicks = 0;
      addr = '0;
      we = 1'b0;
      wdata = '0;
      while (MemReq !== 1'b1 && waitTicks < 20) begin
         tick();
         waitTicks++;
      end
      if (MemReq !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL memReqTimeout: MemReq=%b required 1", MemReq);
         return;
      end
      addr = MemAddr;
      we = MemWe;
      wdata = MemWdata;
      for (int i = 1; i < lat; i++) begin
         tick();
         checks++;
         if (MemReq !== 1'b1 || IReadyF !== 1'b0 || DReadyM !== 1'b0) begin
            errors++;
            $display("[TB] FAIL memReqHeld: MemReq=%b IReadyF=%b DReadyM=%b required 1 0 0",
                     MemReq, IReadyF, DReadyM);
         end
      end
      MemAck = 1'b1;
      MemRdata = rdata;
      tick();
      MemAck = 1'b0;
      MemRdata = $urandom;
      ok = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      IReqF = 0; IAddrF = '0; DReqM = 0; DWeM = 0; DAddrM = '0; DWdataM = '0;
      MemRdata = '0; MemAck = 0;
      tick();
      tick();
      checks++;
      if ({MemReq, MemWe, IReadyF, DReadyM, StallF, StallM} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL resetFlags: got %b required 000000",
                  {MemReq, MemWe, IReadyF, DReadyM, StallF, StallM});
      end
      checks++;
      if (MemAddr !== 32'h0 || MemWdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL resetBus: MemAddr=%h MemWdata=%h required 0 0", MemAddr, MemWdata);
      end
      checks++;
      if (IRdataF !== 32'h0 || DRdataM !== 32'h0) begin
         errors++;
         $display("[TB] FAIL resetRdata: IRdataF=%h DRdataM=%h required 0 0", IRdataF, DRdataM);
      end
      rst_n = 1'b1;
      expIR = '0;
      expDR = '0;
      lastWasData = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      logic [31:0] a, wd;
      logic w;
      int wt;
      bit ok;
      IAddrF = 32'h0000_0010;
      IReqF = 1'b1;
      #1;
      checks++;
      if (StallF !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fetchStallWait: StallF=%b required 1", StallF);
      end
      serveMem(3, 32'h0050_0093, a, w, wd, wt, ok);
      if (!ok) begin IReqF = 0; return; end
      checks++;
      if (wt != 1 || a !== 32'h10 || w !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetchGrant: wait=%0d addr=%h we=%b required 1 00000010 0", wt, a, w);
      end
      expIR = 32'h0050_0093;
      lastWasData = 1'b0;
      checks++;
      if (IReadyF !== 1'b1 || DReadyM !== 1'b0 || IRdataF !== expIR || StallF !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetchReady: IReadyF=%b DReadyM=%b IRdataF=%h StallF=%b required 1 0 %h 0",
                  IReadyF, DReadyM, IRdataF, StallF, expIR);
      end
      IReqF = 1'b0;
      tick();
      checks++;
      if (IReadyF !== 1'b0 || MemReq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetchPulse: IReadyF=%b MemReq=%b required 0 0", IReadyF, MemReq);
      end
   endtask

   task automatic test_load();
      logic [31:0] a, wd;
      logic w;
      int wt;
      bit ok;
      DAddrM = 32'h100;
      DWeM = 1'b0;
      DReqM = 1'b1;
      serveMem(1, 32'hDEAD_BEEF, a, w, wd, wt, ok);
      if (!ok) begin DReqM = 0; return; end
      // Request at cycle 0, MemReq seen after one edge, ready after the next: cycle 2.
      checks++;
      if (wt != 1 || a !== 32'h100 || w !== 1'b0) begin
         errors++;
         $display("[TB] FAIL loadGrant: wait=%0d addr=%h we=%b required 1 00000100 0", wt, a, w);
      end
      expDR = 32'hDEAD_BEEF;
      lastWasData = 1'b1;
      checks++;
      if (DReadyM !== 1'b1 || IReadyF !== 1'b0 || DRdataM !== expDR || StallM !== 1'b0 ||
          IRdataF !== expIR) begin
         errors++;
         $display("[TB] FAIL loadReady: DReadyM=%b IReadyF=%b DRdataM=%h StallM=%b IRdataF=%h required 1 0 %h 0 %h",
                  DReadyM, IReadyF, DRdataM, StallM, IRdataF, expDR, expIR);
      end
      DReqM = 1'b0;
      tick();
      checks++;
      if (DReadyM !== 1'b0) begin
         errors++;
         $display("[TB] FAIL loadPulse: DReadyM=%b required 0", DReadyM);
      end
   endtask

   task automatic test_store();
      logic [31:0] a, wd;
      logic w;
      int wt;
      bit ok;
      DAddrM = 32'h104;
      DWdataM = 32'h1234_5678;
      DWeM = 1'b1;
      DReqM = 1'b1;
      serveMem(2, 32'hCAFE_F00D, a, w, wd, wt, ok);
      if (!ok) begin DReqM = 0; DWeM = 0; return; end
      checks++;
      if (a !== 32'h104 || w !== 1'b1 || wd !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL storeGrant: addr=%h we=%b wdata=%h required 00000104 1 12345678", a, w, wd);
      end
      lastWasData = 1'b1;
      checks++;
      if (DReadyM !== 1'b1 || DRdataM !== expDR || MemWe !== 1'b0) begin
         errors++;
         $display("[TB] FAIL storeReady: DReadyM=%b DRdataM=%h MemWe=%b required 1 %h 0",
                  DReadyM, DRdataM, MemWe, expDR);
      end
      DReqM = 1'b0;
      DWeM = 1'b0;
      tick();
      checks++;
      if (DReadyM !== 1'b0 || DRdataM !== expDR) begin
         errors++;
         $display("[TB] FAIL storeAfter: DReadyM=%b DRdataM=%h required 0 %h", DReadyM, DRdataM, expDR);
      end
   endtask

   task automatic test_spurious_ack();
      for (int i = 0; i < 3; i++) begin
         MemAck = 1'b1;
         MemRdata = $urandom;
         tick();
         checks++;
         if (IReadyF !== 1'b0 || DReadyM !== 1'b0 || MemReq !== 1'b0 ||
             IRdataF !== expIR || DRdataM !== expDR) begin
            errors++;
            $display("[TB] FAIL spuriousAck: IReadyF=%b DReadyM=%b MemReq=%b IRdataF=%h DRdataM=%h required 0 0 0 %h %h",
                     IReadyF, DReadyM, MemReq, IRdataF, DRdataM, expIR, expDR);
         end
      end
      MemAck = 1'b0;
      tick();
   endtask

   // Serves a set of simultaneous requests in the order the model predicts.
   task automatic runRound(input bit wantI, input bit wantD, input bit we,
                           input logic [31:0] iAddr, input logic [31:0] dAddr,
                           input logic [31:0] dWdata, input string tag);
      logic [31:0] a, wd, rdata, expAddr;
      logic w;
      int wt;
      bit ok, cur, pendI, pendD;
      pendI = wantI;
      pendD = wantD;
      IAddrF = iAddr; DAddrM = dAddr; DWdataM = dWdata; DWeM = we;
      IReqF = wantI; DReqM = wantD;
      while (pendI || pendD) begin
         cur = pickData(pendI, pendD);
         rdata = $urandom;
         serveMem($urandom_range(1, 4), rdata, a, w, wd, wt, ok);
         if (!ok) begin IReqF = 0; DReqM = 0; return; end
         expAddr = cur ? dAddr : iAddr;
         checks++;
         if (a !== expAddr || w !== (cur & we) || (cur && we && wd !== dWdata)) begin
            errors++;
            $display("[TB] FAIL %s grant: addr=%h we=%b wdata=%h required %h %b %h",
                     tag, a, w, wd, expAddr, cur & we, dWdata);
         end
         lastWasData = cur;
         if (!cur) expIR = rdata;
         else if (!we) expDR = rdata;
         checks++;
         if ({IReadyF, DReadyM} !== (cur ? 2'b01 : 2'b10) || IRdataF !== expIR || DRdataM !== expDR) begin
            errors++;
            $display("[TB] FAIL %s ready: IReadyF=%b DReadyM=%b IRdataF=%h DRdataM=%h required %b %b %h %h",
                     tag, IReadyF, DReadyM, IRdataF, DRdataM, !cur, cur, expIR, expDR);
         end
         if (cur) begin DReqM = 1'b0; pendD = 0; end
         else begin IReqF = 1'b0; pendI = 0; end
         tick();
         checks++;
         if (IReadyF !== 1'b0 || DReadyM !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s pulse: IReadyF=%b DReadyM=%b required 0 0", tag, IReadyF, DReadyM);
         end
      end
   endtask

   task automatic test_contention();
      for (int r = 0; r < 4; r++) begin
         runRound(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(r * 4), 32'h8000 + 32'(r * 4), 32'h0, "contention");
      end
   endtask

   task automatic test_random();
      bit wi, wd;
      for (int n = 0; n < 25; n++) begin
         wi = 1'($urandom);
         wd = 1'($urandom);
         if (!wi && !wd) wd = 1'b1;
         runRound(wi, wd, 1'($urandom), $urandom, $urandom, $urandom, "random");
      end
   endtask

   task automatic test_reset_abort();
      int waited;
      DAddrM = 32'h200;
      DWeM = 1'b0;
      DReqM = 1'b1;
      waited = 0;
      while (MemReq !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      checks++;
      if (MemReq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abortGrant: MemReq=%b required 1", MemReq);
      end
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (MemReq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abortMemReq: MemReq=%b required 0", MemReq);
      end
      DReqM = 1'b0;
      tick();
      rst_n = 1'b1;
      expIR = '0;
      expDR = '0;
      lastWasData = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (DReadyM !== 1'b0 || MemReq !== 1'b0 || DRdataM !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abortIdle: DReadyM=%b MemReq=%b DRdataM=%h required 0 0 0",
                     DReadyM, MemReq, DRdataM);
         end
      end
   endtask

   initial begin
`ifdef MEM_ARB_RR_EN
      rrEn = 1'b1;
`else
      rrEn = 1'b0;
`endif
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_spurious_ack();
      test_contention();
      test_random();
      test_reset_abort();
      test_contention();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Ports SHALL be (name, direction, width, meaning), clock and reset first:
 clk  in  1  single clock, all state on rising edge.
 rst_n  in  1  reset, asynchronous, active-low.
 IReqF  in  1  fetch read request, held until IReadyF.
 IAddrF  in  32  fetch address, stable while IReqF high.
 IRdataF  out  32  fetched instruction word, valid when IReadyF.
 IReadyF  out  1  one-cycle fetch completion pulse.
 DReqM  in  1  data request, held until DReadyM.
 DWeM  in  1  data request is a write.
 DAddrM  in  32  data address.
 DWdataM  in  32  store data.
 DRdataM  out  32  load data, valid when DReadyM after a read.
 DReadyM  out  1  one-cycle data completion pulse.
 MemReq  out  1  memory request, held until MemAck.
 MemWe  out  1  memory write enable.
 MemAddr  out  32  memory address.
 MemWdata  out  32  memory write data.
 MemRdata  in  32  memory read data, valid with MemAck.
 MemAck  in  1  memory completion, may arrive 1..n cycles after MemReq rises.
 StallF  out  1  hold fetch stage.
 StallM  out  1  hold memory stage.
REQ-002 Reset SHALL be asynchronous and active-low on rst_n; one clock, clk.

Function
REQ-003 FSM states SHALL be IDLE, IFETCH, DACCESS, RESP.
REQ-004 IDLE: DReqM -> DACCESS; else IReqF -> IFETCH; else stay; both pending -> DACCESS (fixed data priority).
REQ-005 On grant, the granted requester's address, write enable and write data SHALL be latched; MemAddr/MemWe/MemWdata SHALL drive the latched values.
REQ-006 MemReq SHALL be 1 exactly in IFETCH and DACCESS; MemWe = latched DWeM in DACCESS, 0 otherwise.
REQ-007 IFETCH/DACCESS with MemAck=1 -> RESP; MemRdata SHALL be captured into IRdataF (IFETCH) or DRdataM (DACCESS read); MemAck=0 -> stay.
REQ-008 Data writes SHALL leave DRdataM unchanged.
REQ-009 RESP SHALL pulse IReadyF or DReadyM (matching completed grant) for exactly one cycle, then -> IDLE unconditionally.
REQ-010 Minimum latency: request seen in IDLE at cycle 0, MemReq at cycle 1, ack at cycle 1 -> Ready at cycle 2.
REQ-011 StallF = IReqF & ~IReadyF; StallM = DReqM & ~DReadyM (combinational).
REQ-012 MemAck in IDLE or RESP SHALL be ignored.
REQ-013 A requester's request still high during its Ready cycle SHALL NOT be re-granted that cycle (RESP never grants).
REQ-014 rst_n low mid-transaction SHALL abort it: MemReq drops immediately, no Ready pulse issued.

Reset
REQ-015 Reset values: state IDLE; MemReq, MemWe, IReadyF, DReadyM = 0; MemAddr, MemWdata, IRdataF, DRdataM = 0.

Configuration
REQ-016 With MEM_ARB_RR_EN defined, simultaneous IReqF and DReqM in IDLE SHALL grant the requester not granted last (reset: fetch counts as last granted, so data first); a 1-bit last-grant register is added.
REQ-017 Without MEM_ARB_RR_EN, REQ-004 fixed data priority applies and no last-grant register exists.

Structure
REQ-018 A shared package SHALL hold the FSM state enum and the 32-bit address/data width constant.
REQ-019 No sub-modules; single flat module.

Verification
REQ-020 Fetch only: IReqF=1, IAddrF=0x0000_0010, MemAck after 3 cycles with MemRdata=0x0050_0093 -> MemAddr=0x10, IReadyF pulse one cycle, IRdataF=0x0050_0093, StallF low in Ready cycle.
REQ-021 Load: DReqM=1, DWeM=0, DAddrM=0x100, MemAck immediate, MemRdata=0xDEAD_BEEF -> DReadyM at cycle 2, DRdataM=0xDEAD_BEEF.
REQ-022 Store: DWeM=1, DAddrM=0x104, DWdataM=0x1234_5678 -> MemWe=1, MemWdata=0x1234_5678, DRdataM unchanged after DReadyM.
REQ-023 Contention: IReqF and DReqM both high in IDLE -> DACCESS first, IFETCH next; with MEM_ARB_RR_EN and repeated contention, grants alternate D,I,D,I.
REQ-024 Reset abort: rst_n low during DACCESS before MemAck -> MemReq 0 same cycle, no DReadyM, state IDLE.
REQ-025 Spurious MemAck=1 in IDLE with no requests -> no Ready pulse, outputs unchanged.
